// File: rtl/rtc_bus_arbiter.sv
// Round-robin two-master sequencer for the RTC register port.
// One RTC access per grant; the granted master gets a one-cycle ready pulse and registered read data.
module rtc_bus_arbiter #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ACCESS_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_cs,
  output logic              s_wr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              grant,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [3:0] CntInit = 4'(ACCESS_CYC - 1);

  state_e     state;
  logic       last_grant;
  logic       acc_wr;
  logic [3:0] cnt;
  logic       pick;

  // On a tie the master that did not win last time gets the port.
  assign pick = (m0_req && m1_req) ? ~last_grant : m1_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      last_grant <= 1'b1;
      acc_wr     <= 1'b0;
      cnt        <= '0;
      grant      <= 1'b0;
      busy       <= 1'b0;
      s_cs       <= 1'b0;
      s_wr       <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      m0_ready   <= 1'b0;
      m1_ready   <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (m0_req || m1_req) begin
            state      <= StAccess;
            busy       <= 1'b1;
            s_cs       <= 1'b1;
            s_wr       <= pick ? m1_wr : m0_wr;
            acc_wr     <= pick ? m1_wr : m0_wr;
            s_addr     <= pick ? m1_addr : m0_addr;
            s_wdata    <= pick ? m1_wdata : m0_wdata;
            cnt        <= CntInit;
            grant      <= pick;
            last_grant <= pick;
          end
        end
        StAccess: begin
          // Write strobe lasts only the first access cycle; address and data stay frozen.
          s_wr <= 1'b0;
          if (cnt == 4'd0) begin
            s_cs <= 1'b0;
            if (!acc_wr) begin
              if (grant) m1_rdata <= s_rdata;
              else       m0_rdata <= s_rdata;
            end
            m0_ready <= ~grant;
            m1_ready <= grant;
            state    <= StResp;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StResp: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: one instance with ACCESS_CYC=1, one with ACCESS_CYC=3.
module tb_rtc_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
  logic [3:0]  m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic        m0_ready, m1_ready, s_cs, s_wr, grant, busy;
  logic [31:0] m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [3:0]  s_addr;

  logic        b_m0_req = 0, b_m0_wr = 0;
  logic [3:0]  b_m0_addr = 0;
  logic [31:0] b_m0_wdata = 0;
  logic        b_m0_ready, b_m1_ready, b_s_cs, b_s_wr, b_grant, b_busy;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_wdata;
  logic [3:0]  b_s_addr;

  int errors = 0;
  int checks = 0;
  int r0_cnt = 0;
  int r1_cnt = 0;
  int snap0, snap1;
  logic got;

  always #5 clk = ~clk;

  // RTC register file model: fixed contents, combinational read.
  always_comb begin
    case (s_addr)
      4'd1:    s_rdata = 32'h0000_0017;
      4'd3:    s_rdata = 32'hA5A5_0003;
      default: s_rdata = {28'h0, s_addr};
    endcase
  end

  always @(posedge clk) begin
    if (m0_ready) r0_cnt++;
    if (m1_ready) r1_cnt++;
  end

  rtc_bus_arbiter #(.ADDR_W(4), .DATA_W(32), .ACCESS_CYC(1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_cs(s_cs), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .grant(grant), .busy(busy)
  );

  rtc_bus_arbiter #(.ADDR_W(4), .DATA_W(32), .ACCESS_CYC(3)) dut3 (
    .clk(clk), .reset(reset),
    .m0_req(b_m0_req), .m0_wr(b_m0_wr), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
    .m1_req(1'b0), .m1_wr(1'b0), .m1_addr(4'h0), .m1_wdata(32'h0),
    .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
    .s_cs(b_s_cs), .s_wr(b_s_wr), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_rdata(32'h0),
    .grant(b_grant), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Step to the first cycle showing a ready pulse, bounded.
  task automatic wait_ready(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("ready_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_s_cs", 32'(s_cs), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_grant", 32'(grant), 32'(0));
    check("rst_ready", 32'({m0_ready, m1_ready}), 32'(0));
    check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    reset = 1'b0;

    // 1: m0 write addr 2
    @(negedge clk);
    m0_req = 1; m0_wr = 1; m0_addr = 4'd2; m0_wdata = 32'h0000_003B;
    @(negedge clk);
    check("t1_cs_wr", 32'({s_cs, s_wr}), 32'(2'b11));
    check("t1_addr", 32'(s_addr), 32'(2));
    check("t1_wdata", s_wdata, 32'h0000_003B);
    check("t1_grant_busy", 32'({grant, busy}), 32'(2'b01));
    check("t1_no_ready", 32'(m0_ready), 32'(0));
    @(negedge clk);
    check("t1_cs_drop", 32'({s_cs, s_wr}), 32'(0));
    check("t1_ready", 32'({m0_ready, m1_ready}), 32'(2'b10));
    m0_req = 0;
    @(negedge clk);
    check("t1_idle", 32'({m0_ready, busy}), 32'(0));
    check("t1_wr_no_rdata", m0_rdata, 32'h0);

    // m0 read addr 2 to give m0_rdata a known non-zero value
    m0_req = 1; m0_wr = 0; m0_addr = 4'd2;
    got = 1'b0;
    wait_ready(got);
    m0_req = 0;
    check("t1b_m0_rdata", m0_rdata, 32'h2);

    // 2: m1 read addr 1
    @(negedge clk);
    m1_req = 1; m1_wr = 0; m1_addr = 4'd1;
    @(negedge clk);
    check("t2_grant", 32'({grant, s_cs, s_wr}), 32'(3'b110));
    check("t2_addr", 32'(s_addr), 32'(1));
    @(negedge clk);
    check("t2_ready", 32'({m0_ready, m1_ready, s_wr}), 32'(3'b010));
    check("t2_m1_rdata", m1_rdata, 32'h0000_0017);
    check("t2_m0_rdata", m0_rdata, 32'h2);
    m1_req = 0;
    @(negedge clk);

    // 3: both requesting from reset -> strict alternation
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    snap0 = r0_cnt; snap1 = r1_cnt;
    m0_req = 1; m0_wr = 0; m0_addr = 4'd4;
    m1_req = 1; m1_wr = 0; m1_addr = 4'd1;
    for (int i = 0; i < 8; i++) begin
      wait_ready(got);
      if (got) begin
        check($sformatf("t3_grant%0d", i), 32'(grant), 32'(i % 2));
        check($sformatf("t3_ready%0d", i), 32'({m0_ready, m1_ready}), (i % 2) ? 32'(1) : 32'(2));
      end
    end
    m0_req = 0; m1_req = 0;
    repeat (4) @(negedge clk);
    check("t3_cnt0", 32'(r0_cnt - snap0), 32'(4));
    check("t3_cnt1", 32'(r1_cnt - snap1), 32'(4));
    check("t3_rdata", m0_rdata, 32'h4);

    // 4: ACCESS_CYC=3 write on second instance
    b_m0_req = 1; b_m0_wr = 1; b_m0_addr = 4'd5; b_m0_wdata = 32'h0000_1234;
    @(negedge clk);
    check("t4_c1", 32'({b_s_cs, b_s_wr, b_m0_ready}), 32'(3'b110));
    @(negedge clk);
    check("t4_c2", 32'({b_s_cs, b_s_wr, b_m0_ready}), 32'(3'b100));
    @(negedge clk);
    check("t4_c3", 32'({b_s_cs, b_s_wr, b_m0_ready}), 32'(3'b100));
    check("t4_frozen", {b_s_wdata[27:0], b_s_addr}, 32'h0001_2345);
    @(negedge clk);
    check("t4_ready", 32'({b_s_cs, b_m0_ready, b_m1_ready}), 32'(3'b010));
    b_m0_req = 0;
    @(negedge clk);
    check("t4_done", 32'({b_m0_ready, b_busy}), 32'(0));

    // 5: m1 read, req dropped during ACCESS
    m1_req = 1; m1_wr = 0; m1_addr = 4'd3;
    @(negedge clk);
    check("t5_grant", 32'({grant, s_cs}), 32'(2'b11));
    m1_req = 0;
    snap1 = r1_cnt;
    @(negedge clk);
    check("t5_ready", 32'(m1_ready), 32'(1));
    check("t5_rdata", m1_rdata, 32'hA5A5_0003);
    repeat (3) @(negedge clk);
    check("t5_idle", 32'({s_cs, busy}), 32'(0));
    check("t5_one_ready", 32'(r1_cnt - snap1), 32'(1));

    // 6: reset during ACCESS, then tie goes to m0
    m0_req = 1; m0_wr = 1; m0_addr = 4'd6;
    @(negedge clk);
    check("t6_in_access", 32'({s_cs, grant}), 32'(2'b10));
    snap0 = r0_cnt;
    reset = 1'b1;
    #1;
    check("t6_abort", 32'({s_cs, s_wr, busy, m0_ready}), 32'(0));
    check("t6_addr", 32'(s_addr), 32'(0));
    m0_req = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_no_ready", 32'(r0_cnt - snap0), 32'(0));
    m0_req = 1; m0_wr = 0; m0_addr = 4'd2;
    m1_req = 1; m1_wr = 0; m1_addr = 4'd1;
    @(negedge clk);
    check("t6_tie", 32'({grant, s_cs}), 32'(2'b01));
    wait_ready(got);
    check("t6_tie_ready", 32'({m0_ready, m1_ready}), 32'(2'b10));
    m0_req = 0; m1_req = 0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
